// File: rtl/ucsbece154b_icache_if.sv
// ----------------------------------------------------------------------------
// ucsbece154b_icache_if
// Bundles the instruction-cache signals that are not clock/reset:
//   fetch side : PCF_i, ReadEnable_i  -> cache ; Instruction_o, Ready_o <- cache
//   memory side: MemDataIn_i, MemDataReady_i -> cache ;
//                MemReadAddress_o, MemReadRequest_o <- cache
//   statistics : HitCount_o, MissCount_o <- cache
// Modports:
//   master : the environment (core fetch stage + instruction memory model)
//   slave  : the cache itself
// ----------------------------------------------------------------------------
interface ucsbece154b_icache_if;
    logic [31:0] PCF_i;
    logic        ReadEnable_i;
    logic [31:0] Instruction_o;
    logic        Ready_o;
    logic [31:0] MemReadAddress_o;
    logic        MemReadRequest_o;
    logic [31:0] MemDataIn_i;
    logic        MemDataReady_i;
    logic [31:0] HitCount_o;
    logic [31:0] MissCount_o;

    modport master (
        output PCF_i, ReadEnable_i, MemDataIn_i, MemDataReady_i,
        input  Instruction_o, Ready_o, MemReadAddress_o, MemReadRequest_o,
               HitCount_o, MissCount_o
    );

    modport slave (
        input  PCF_i, ReadEnable_i, MemDataIn_i, MemDataReady_i,
        output Instruction_o, Ready_o, MemReadAddress_o, MemReadRequest_o,
               HitCount_o, MissCount_o
    );
endinterface

// File: rtl/ucsbece154b_icache.sv
// ----------------------------------------------------------------------------
// ucsbece154b_icache
// Set-associative, read-only instruction cache between the pipelined core's
// fetch stage and instruction memory. Misses refill a whole block, one word
// per MemDataReady_i beat, into a line buffer; the line is written into the
// array (and becomes visible) only on the last beat.
//
// Ports:
//   clk    in  clock, all state updates on posedge
//   reset  in  synchronous, active-high reset
//   bus    ucsbece154b_icache_if.slave
//          PCF_i/ReadEnable_i in, Instruction_o/Ready_o out (fetch port)
//          MemReadAddress_o/MemReadRequest_o out, MemDataIn_i/MemDataReady_i in
//          HitCount_o/MissCount_o out (statistics, wrap modulo 2^32)
//
// Configuration macro: ICACHE_EARLY_RESTART_EN
//   defined   : the refill beat carrying the requested word is forwarded to
//               the core in the same cycle when PCF_i still equals the
//               missing PC.
//   undefined : Ready_o comes only from the IDLE lookup.
// ----------------------------------------------------------------------------
module ucsbece154b_icache #(
    parameter int NUM_SETS        = 8,
    parameter int NUM_WAYS        = 2,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    ucsbece154b_icache_if.slave    bus
);

    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [1:0] {IDLE, REQ, REFILL} state_t;

    // Address split of the fetch PC
    logic [OFF_W-1:0] pc_off;
    logic [IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0] pc_tag;
    logic             unused_pc_bits;

    assign pc_off         = bus.PCF_i[2 +: OFF_W];
    assign pc_idx         = bus.PCF_i[2 + OFF_W +: IDX_W];
    assign pc_tag         = bus.PCF_i[31 -: TAG_W];
    assign unused_pc_bits = ^bus.PCF_i[1:0];

    // Control state
    state_t               state_q, state_d;
    logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]  valid_d [NUM_SETS];
    logic [WAY_W-1:0]     rr_q    [NUM_SETS];
    logic [WAY_W-1:0]     rr_d    [NUM_SETS];
    logic [OFF_W-1:0]     beat_q, beat_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          hit_cnt_q, hit_cnt_d;
    logic [31:0]          miss_cnt_q, miss_cnt_d;

    // Data-path state (not reset)
    logic [TAG_W-1:0]     tag_q  [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]     tag_d  [NUM_SETS][NUM_WAYS];
    logic [31:0]          data_q [NUM_SETS][NUM_WAYS][WORDS_PER_BLOCK];
    logic [31:0]          data_d [NUM_SETS][NUM_WAYS][WORDS_PER_BLOCK];
    logic [31:0]          line_q [WORDS_PER_BLOCK];
    logic [31:0]          line_d [WORDS_PER_BLOCK];
    logic [TAG_W-1:0]     tag_l_q, tag_l_d;
    logic [IDX_W-1:0]     idx_l_q, idx_l_d;
    logic [OFF_W-1:0]     off_l_q, off_l_d;

    // Lookup
    logic                 hit;
    logic [WAY_W-1:0]     hit_way;
    logic [31:0]          hit_word;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[pc_idx][w] && (tag_q[pc_idx][w] == pc_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign hit_word = data_q[pc_idx][hit_way][pc_off];

    // Victim for the latched set: lowest invalid way, else round-robin pointer.
    // Valid bits of that set cannot change during a refill, so evaluating
    // this on the last beat is equivalent to choosing it at miss time.
    logic [WAY_W-1:0]     victim;
    logic                 found_free;

    always_comb begin
        victim     = rr_q[idx_l_q];
        found_free = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!found_free && !valid_q[idx_l_q][w]) begin
                victim     = WAY_W'(w);
                found_free = 1'b1;
            end
        end
    end

    // Next state and outputs
    logic                 ready;
    logic [31:0]          instr;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        rr_d       = rr_q;
        beat_d     = beat_q;
        addr_d     = addr_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        tag_d      = tag_q;
        data_d     = data_q;
        line_d     = line_q;
        tag_l_d    = tag_l_q;
        idx_l_d    = idx_l_q;
        off_l_d    = off_l_q;
        ready      = 1'b0;
        instr      = '0;

        case (state_q)
            IDLE: begin
                // Miss start is independent of ReadEnable_i: the core derives
                // ReadEnable from Ready, so qualifying here would form a loop.
                if (hit) begin
                    ready = 1'b1;
                    instr = hit_word;
                end else begin
                    state_d    = REQ;
                    tag_l_d    = pc_tag;
                    idx_l_d    = pc_idx;
                    off_l_d    = pc_off;
                    addr_d     = {pc_tag, pc_idx, {(OFF_W + 2){1'b0}}};
                    beat_d     = '0;
                    miss_cnt_d = miss_cnt_q + 32'd1;
                end
            end

            REQ: begin
                state_d = REFILL;
            end

            REFILL: begin
                if (bus.MemDataReady_i) begin
`ifdef ICACHE_EARLY_RESTART_EN
                    if ((beat_q == off_l_q) &&
                        ({pc_tag, pc_idx, pc_off} == {tag_l_q, idx_l_q, off_l_q})) begin
                        ready = 1'b1;
                        instr = bus.MemDataIn_i;
                    end
`endif
                    line_d[beat_q] = bus.MemDataIn_i;
                    beat_d         = beat_q + 1'b1;
                    if (beat_q == OFF_W'(WORDS_PER_BLOCK - 1)) begin
                        // Last beat comes straight from the bus, earlier ones
                        // from the line buffer.
                        for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
                            data_d[idx_l_q][victim][k] =
                                (k == WORDS_PER_BLOCK - 1) ? bus.MemDataIn_i : line_q[k];
                        end
                        tag_d[idx_l_q][victim]   = tag_l_q;
                        valid_d[idx_l_q][victim] = 1'b1;
                        rr_d[idx_l_q]            =
                            WAY_W'((int'(rr_q[idx_l_q]) + 1) % NUM_WAYS);
                        state_d                  = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Valid bits may still be set during the reset cycle itself.
        if (reset) begin
            ready = 1'b0;
            instr = '0;
        end

        if (ready && bus.ReadEnable_i) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            addr_q     <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            addr_q     <= addr_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            valid_q    <= valid_d;
            rr_q       <= rr_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q   <= tag_d;
        data_q  <= data_d;
        line_q  <= line_d;
        tag_l_q <= tag_l_d;
        idx_l_q <= idx_l_d;
        off_l_q <= off_l_d;
    end

    assign bus.Ready_o          = ready;
    assign bus.Instruction_o    = instr;
    assign bus.MemReadRequest_o = (state_q == REQ);
    assign bus.MemReadAddress_o = addr_q;
    assign bus.HitCount_o       = hit_cnt_q;
    assign bus.MissCount_o      = miss_cnt_q;

endmodule
